fetch_ctrl: RTL

- Sequences the instruction-memory port for the front end.
- Owns the fetch PC and issues single-cycle imem read requests, with at most one outstanding.
- Delivers each returned instruction and its PC into the dispatch FIFO, holding it in a one-entry skid register under back-pressure.
- Redirects to a ROB-supplied PC on flush and discards any stale in-flight response.

---
 rtl/fetch_ctrl_if.sv | 54 +++++
 rtl/fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the fetch controller's instruction-memory port, dispatch-FIFO
//   enqueue port and ROB redirect into one interface.
//
//   Signals:
//     flush, flush_pc          ROB redirect pulse and target
//     fifo_full                dispatch FIFO back-pressure
//     imem_addr, imem_rmask    memory request (4'hF for one cycle = request)
//     imem_rdata, imem_resp    memory response (single-cycle pulse)
//     enq, enq_inst, enq_pc    push into the dispatch FIFO
//     fetch_stall              high in any cycle without an enqueue
//     perf_*                   event counters, present only with FETCH_PERF_EN
//
//   Modports:
//     master  the fetch controller
//     slave   the surrounding memory / FIFO / ROB environment
//
//   Optional feature macro: FETCH_PERF_EN
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fifo_full;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        enq;
    logic [31:0] enq_inst;
    logic [31:0] enq_pc;
    logic        fetch_stall;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_discarded;
`endif

    modport master (
        input  flush, flush_pc, fifo_full, imem_rdata, imem_resp,
        output imem_addr, imem_rmask, enq, enq_inst, enq_pc, fetch_stall
`ifdef FETCH_PERF_EN
        , output perf_fetched, perf_stall_cycles, perf_discarded
`endif
    );

    modport slave (
        output flush, flush_pc, fifo_full, imem_rdata, imem_resp,
        input  imem_addr, imem_rmask, enq, enq_inst, enq_pc, fetch_stall
`ifdef FETCH_PERF_EN
        , input perf_fetched, perf_stall_cycles, perf_discarded
`endif
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Front-end fetch sequencer. Owns the fetch PC, issues single-cycle
//   instruction-memory reads with at most one outstanding, and pushes each
//   returned instruction with its PC into the dispatch FIFO. A one-entry skid
//   register holds a response that arrives while the FIFO is full. A ROB
//   flush redirects the PC; a response still in flight at that point is
//   waited for and discarded.
//
//   Parameters:
//     RESET_PC   fetch PC loaded on reset
//
//   Ports:
//     clk        clock
//     rst        asynchronous reset, active-high
//     bus        fetch_ctrl_if.master (memory, FIFO, redirect signals)
//
//   Optional feature macro: FETCH_PERF_EN
//     Adds saturating counters perf_fetched, perf_stall_cycles and
//     perf_discarded to the interface. Core behaviour is unchanged.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hAAAAA000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    // IDLE : no request outstanding, ready to issue
    // WAIT : one request outstanding, response is for pc_r
    // HOLD : response for pc_r parked in the skid register
    // DRAIN: a request issued before a flush is still in flight
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] skid_r;
    logic [31:0] skid_next_s;

    logic        req_s;
    logic [31:0] req_addr_s;
    logic        enq_s;
    logic [31:0] enq_inst_s;
    logic [31:0] enq_pc_s;
    logic [31:0] flush_target_s;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        // Natural 32-bit wrap: 32'hFFFFFFFC + 4 -> 32'h0
        return pc + 32'd4;
    endfunction

    // Redirect targets are always word aligned
    assign flush_target_s = bus.flush_pc & 32'hFFFF_FFFC;

    // State, PC and skid registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            skid_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            skid_r  <= skid_next_s;
        end
    end

    // Next-state, PC update, request and enqueue decode
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        skid_next_s  = skid_r;
        req_s        = 1'b0;
        req_addr_s   = pc_r;
        enq_s        = 1'b0;
        enq_inst_s   = 32'h0000_0000;
        enq_pc_s     = 32'h0000_0000;

        case (state_r)
            IDLE: begin
                // Any response seen here is stale or spurious and is ignored
                if (bus.flush) begin
                    pc_next_s = flush_target_s;
                end else if (!bus.fifo_full) begin
                    req_s        = 1'b1;
                    req_addr_s   = pc_r;
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end

            WAIT: begin
                if (bus.flush) begin
                    // The response (now or later) belongs to the old path
                    pc_next_s = flush_target_s;
                    if (bus.imem_resp) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end else if (bus.imem_resp) begin
                    if (!bus.fifo_full) begin
                        // Deliver and immediately request the next word;
                        // memory accepts a request in its response cycle
                        enq_s        = 1'b1;
                        enq_inst_s   = bus.imem_rdata;
                        enq_pc_s     = pc_r;
                        pc_next_s    = pc_inc(pc_r);
                        req_s        = 1'b1;
                        req_addr_s   = pc_inc(pc_r);
                        state_next_s = WAIT;
                    end else begin
                        // pc_r stays as the tag of the parked instruction
                        skid_next_s  = bus.imem_rdata;
                        state_next_s = HOLD;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end

            HOLD: begin
                if (bus.flush) begin
                    skid_next_s  = 32'h0000_0000;
                    pc_next_s    = flush_target_s;
                    state_next_s = IDLE;
                end else if (!bus.fifo_full) begin
                    enq_s        = 1'b1;
                    enq_inst_s   = skid_r;
                    enq_pc_s     = pc_r;
                    pc_next_s    = pc_inc(pc_r);
                    req_s        = 1'b1;
                    req_addr_s   = pc_inc(pc_r);
                    state_next_s = WAIT;
                end else begin
                    state_next_s = HOLD;
                end
            end

            DRAIN: begin
                // A second flush only retargets; the stale response is
                // still the event that frees the memory port
                if (bus.flush) begin
                    pc_next_s = flush_target_s;
                end else begin
                    pc_next_s = pc_r;
                end
                if (bus.imem_resp) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Port outputs; reset forces the request and enqueue strobes low even
    // though IDLE would otherwise issue combinationally
    always_comb begin
        bus.imem_addr = req_addr_s;
        if (rst) begin
            bus.imem_rmask  = 4'h0;
            bus.enq         = 1'b0;
            bus.enq_inst    = 32'h0000_0000;
            bus.enq_pc      = 32'h0000_0000;
            bus.fetch_stall = 1'b1;
        end else begin
            bus.imem_rmask  = req_s ? 4'hF : 4'h0;
            bus.enq         = enq_s;
            bus.enq_inst    = enq_inst_s;
            bus.enq_pc      = enq_pc_s;
            bus.fetch_stall = !enq_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_cycles_r;
    logic [31:0] perf_discarded_r;
    logic        discard_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
    endfunction

    // A response is dropped when it lands in DRAIN or together with a flush in WAIT
    assign discard_s = bus.imem_resp &&
                       ((state_r == DRAIN) || ((state_r == WAIT) && bus.flush));

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_r      <= 32'h0000_0000;
            perf_stall_cycles_r <= 32'h0000_0000;
            perf_discarded_r    <= 32'h0000_0000;
        end else begin
            perf_fetched_r      <= sat_inc(perf_fetched_r, enq_s);
            perf_stall_cycles_r <= sat_inc(perf_stall_cycles_r, !enq_s);
            perf_discarded_r    <= sat_inc(perf_discarded_r, discard_s);
        end
    end

    assign bus.perf_fetched      = perf_fetched_r;
    assign bus.perf_stall_cycles = perf_stall_cycles_r;
    assign bus.perf_discarded    = perf_discarded_r;
`endif

endmodule
